// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with watermarks, sticky errors, flush and FWFT/registered read
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter bit FWFT       = 1'b1,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q, count_n;
  logic                  wr_acc, rd_acc;
  logic                  overflow_n, underflow_n;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_acc = write_i && !full_o && !flush_i;
  assign rd_acc = read_i && !empty_o && !flush_i;

  // Setting beats clearing so an error in the clear cycle is never lost.
  always_comb begin
    count_n     = count_q;
    overflow_n  = clr_err_i ? 1'b0 : overflow_o;
    underflow_n = clr_err_i ? 1'b0 : underflow_o;
    if (flush_i) begin
      count_n = '0;
    end else begin
      if (wr_acc && !rd_acc) count_n = count_q + CNT_W'(1);
      if (rd_acc && !wr_acc) count_n = count_q - CNT_W'(1);
      if (write_i && full_o) overflow_n = 1'b1;
      if (read_i && empty_o) underflow_n = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
        if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      end
      count_q        <= count_n;
      full_o         <= (count_n == FULL_CNT);
      empty_o        <= (count_n == '0);
      almost_full_o  <= (count_n >= AF_CNT);
      almost_empty_o <= (count_n <= AE_CNT);
      overflow_o     <= overflow_n;
      underflow_o    <= underflow_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr] <= wr_data_i;
  end

  assign count_o = count_q;

  generate
    if (FWFT) begin : g_fwft
      assign rd_data_o  = mem[rd_ptr];
      assign rd_valid_o = !empty_o;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr];
        end
      end
      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed vector bench for sync_fifo_ctrl in FWFT and registered-read builds
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, wr, rd, clr;
  logic [7:0] wdata;

  logic [7:0] f_data, r_data;
  logic       f_valid, r_valid;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic       r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [2:0] f_cnt, r_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(6), .FWFT(1'b1)) u_fwft (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .write_i(wr), .wr_data_i(wdata),
    .read_i(rd), .rd_data_o(f_data), .rd_valid_o(f_valid), .full_o(f_full),
    .empty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_cnt),
    .overflow_o(f_ovf), .underflow_o(f_udf), .clr_err_i(clr));

  sync_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(6), .FWFT(1'b0)) u_reg (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .write_i(wr), .wr_data_i(wdata),
    .read_i(rd), .rd_data_o(r_data), .rd_valid_o(r_valid), .full_o(r_full),
    .empty_o(r_empty), .almost_full_o(r_af), .almost_empty_o(r_ae), .count_o(r_cnt),
    .overflow_o(r_ovf), .underflow_o(r_udf), .clr_err_i(clr));

  typedef struct {
    logic       flush, wr, rd, clr;
    logic [7:0] wdata;
    int         cnt;
    logic       full, empty, af, ae, ovf, udf;
    logic       rv;
    logic [7:0] rdata;
    logic       chk_fd;
    logic [7:0] fdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic fl, w, input logic [7:0] wd, input logic r, c,
                              input int n, input logic fu, em, af, ae, ov, ud,
                              input logic rv, input logic [7:0] rdt,
                              input logic cf, input logic [7:0] fd);
    vec_t v;
    v.flush = fl; v.wr = w; v.wdata = wd; v.rd = r; v.clr = c;
    v.cnt = n; v.full = fu; v.empty = em; v.af = af; v.ae = ae; v.ovf = ov; v.udf = ud;
    v.rv = rv; v.rdata = rdt; v.chk_fd = cf; v.fdata = fd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic fl, w, input logic [7:0] wd, input logic r, c);
    flush = fl; wr = w; wdata = wd; rd = r; clr = c;
    @(posedge clk);
    #1;
    flush = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic check_status(input string tag, input int n, input logic fu, em, af, ae, ov, ud);
    check({tag, " f_count"}, 32'(f_cnt), 32'(n));
    check({tag, " r_count"}, 32'(r_cnt), 32'(n));
    check({tag, " flags"}, {26'd0, f_full, f_empty, f_af, f_ae, f_ovf, f_udf},
          {26'd0, fu, em, af, ae, ov, ud});
    check({tag, " r_flags"}, {26'd0, r_full, r_empty, r_af, r_ae, r_ovf, r_udf},
          {26'd0, fu, em, af, ae, ov, ud});
    check({tag, " f_valid"}, 32'(f_valid), 32'(!em));
  endtask

  task automatic check_reset(input string tag);
    check_status(tag, 0, 0, 1, 0, 1, 0, 0);
    check({tag, " r_valid"}, 32'(r_valid), 32'd0);
    check({tag, " r_data"}, 32'(r_data), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; wdata = '0;
    #2;
    check_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    //        fl wr wd    rd clr  cnt fu em af ae ov ud  rv rdata  cf fdata
    vq.push_back(mk(0, 1, 8'h10, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 8'h10));
    vq.push_back(mk(0, 1, 8'h11, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 8'h10));
    vq.push_back(mk(0, 1, 8'h12, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h10));
    vq.push_back(mk(0, 1, 8'h13, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h10));
    vq.push_back(mk(0, 1, 8'h14, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h10));
    vq.push_back(mk(0, 1, 8'h15, 0, 0, 6, 1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h10));
    vq.push_back(mk(0, 1, 8'h99, 1, 0, 5, 0, 0, 1, 0, 1, 0, 1, 8'h10, 1, 8'h11));
    vq.push_back(mk(0, 1, 8'h16, 0, 0, 6, 1, 0, 1, 0, 1, 0, 0, 8'h00, 1, 8'h11));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 6, 1, 0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h11));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 5, 0, 0, 1, 0, 0, 0, 1, 8'h11, 1, 8'h12));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 4, 0, 0, 1, 0, 0, 0, 1, 8'h12, 1, 8'h13));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 8'h13, 1, 8'h14));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 8'h14, 1, 8'h15));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 8'h15, 1, 8'h16));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 8'h16, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 8'h00));
    vq.push_back(mk(0, 1, 8'h20, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 8'h00, 1, 8'h20));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h00, 1, 8'h20));

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vq[i].flush, vq[i].wr, vq[i].wdata, vq[i].rd, vq[i].clr);
      check_status(tag, vq[i].cnt, vq[i].full, vq[i].empty, vq[i].af, vq[i].ae,
                   vq[i].ovf, vq[i].udf);
      check({tag, " r_valid"}, 32'(r_valid), 32'(vq[i].rv));
      if (vq[i].rv) check({tag, " r_data"}, 32'(r_data), 32'(vq[i].rdata));
      if (vq[i].chk_fd) check({tag, " f_data"}, 32'(f_data), 32'(vq[i].fdata));
    end

    // Flush beats a same-cycle write; memory is reused from slot 0 afterwards.
    step(0, 1, 8'h21, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    check_status("pre_flush", 3, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h77, 0, 0);
    check_status("flush", 0, 0, 1, 0, 1, 0, 0);
    check("flush r_valid", 32'(r_valid), 32'd0);
    step(0, 1, 8'h55, 0, 0);
    check("post_flush f_data", 32'(f_data), 32'h55);
    step(0, 0, 8'h00, 1, 0);
    check("post_flush r_data", 32'(r_data), 32'h55);
    check("post_flush r_valid", 32'(r_valid), 32'd1);
    step(0, 0, 8'h00, 0, 0);
    check("idle r_valid", 32'(r_valid), 32'd0);
    check("idle r_data hold", 32'(r_data), 32'h55);

    // Registered read: valid for exactly one cycle, data then holds.
    step(0, 1, 8'hAA, 0, 0);
    step(0, 1, 8'hBB, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    check("aa r_data", 32'(r_data), 32'hAA);
    check("aa r_valid", 32'(r_valid), 32'd1);
    check("aa f_data", 32'(f_data), 32'hBB);
    check("aa count", 32'(r_cnt), 32'd1);
    step(0, 0, 8'h00, 0, 0);
    check("aa r_valid drop", 32'(r_valid), 32'd0);
    check("aa r_data hold", 32'(r_data), 32'hAA);

    // Asynchronous reset landing between edges mid-burst.
    step(0, 1, 8'h01, 0, 0);
    step(0, 1, 8'h02, 0, 0);
    check_status("pre_rst", 3, 0, 0, 0, 0, 0, 0);
    wr = 1'b1; wdata = 8'h03;
    #3 rst = 1'b1;
    #1 check_reset("async_rst");
    @(posedge clk);
    #1 check_reset("rst_hold");
    #3 rst = 1'b0;
    wr = 1'b0;
    @(posedge clk);
    #1 check_reset("rst_release");
    step(0, 1, 8'h66, 0, 0);
    check_status("post_rst", 1, 0, 0, 0, 1, 0, 0);
    check("post_rst f_data", 32'(f_data), 32'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised single-clock FIFO: the next generation of the team's synchronous circular-queue buffer. On top of basic read/write it supports any depth of 2 or more (power of two not required), a selectable FWFT or registered-read port, and a live occupancy count. It also provides programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer pipelines that need back-pressure watermarks rather than bare full/empty.

## Interface
- DATA_WIDTH, 32, word width in bits
- FIFO_DEPTH, 32, number of words stored; ≥ 2, any integer
- FWFT, 1, 1 = head word visible combinationally on rd_data_o; 0 = registered read
- AF_THRESH, FIFO_DEPTH-2, almost_full_o asserted when count ≥ AF_THRESH; legal range 1..FIFO_DEPTH
- AE_THRESH, 2, almost_empty_o asserted when count ≤ AE_THRESH; legal range 0..FIFO_DEPTH-1
- CNT_W (local), $clog2(FIFO_DEPTH+1), count width
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous empty request
- write_i  in  1  write request
- wr_data_i  in  DATA_WIDTH  write data
- read_i  in  1  read request
- rd_data_o  out  DATA_WIDTH  read data
- rd_valid_o  out  1  FWFT=0 only: rd_data_o holds a freshly read word; tied to !empty_o when FWFT=1
- full_o, empty_o  out  1 each  status
- almost_full_o, almost_empty_o  out  1 each  watermark status
- count_o  out  CNT_W  words currently stored
- overflow_o, underflow_o  out  1 each  sticky error flags
- clr_err_i  in  1  synchronous clear of the sticky error flags

## Operation
- Storage is a DEPTH-entry memory plus write and read pointers of width $clog2(FIFO_DEPTH).
  - Each pointer increments on an accepted access.
  - A pointer at FIFO_DEPTH-1 wraps to 0. There is no reliance on binary overflow.
- The count register is the single source of truth for status:
  - full_o = (count == FIFO_DEPTH)
  - empty_o = (count == 0)
  - almost flags are compared against the thresholds above
- Write is accepted iff write_i && !full_o. There is no same-cycle read-frees-slot bypass.
- Read is accepted iff read_i && !empty_o.
- Count update per cycle:
  - write accepted alone: +1
  - read accepted alone: −1
  - both accepted: unchanged; both pointers advance
- Rejected requests leave all state unchanged. They set the matching error flag:
  - write_i && full_o sets overflow_o
  - read_i && empty_o sets underflow_o
- Write+read when empty: write is accepted, read is rejected and sets underflow_o. Write+read when full: the mirror case, setting overflow_o.
- Error flags:
  - clr_err_i clears both flags.
  - If a new error occurs in the same cycle as clr_err_i, setting wins and the flag stays 1.
- flush_i has priority over write_i and read_i in the same cycle.
  - Pointers and count go to 0; status returns to its reset values.
  - Memory contents are not cleared.
  - No error flags are set during a flush cycle.
- FWFT=1: rd_data_o = mem[rd_ptr] combinationally. The value is meaningful only while !empty_o.
- FWFT=0: on an accepted read, rd_data_o <= mem[rd_ptr] and rd_valid_o <= 1.
  - Otherwise rd_valid_o <= 0 and rd_data_o holds its last value.
  - A flush clears rd_valid_o.

## Timing
- Reset values (asynchronous, applied immediately):
  - pointers 0, count_o 0
  - empty_o 1, full_o 0
  - almost_empty_o 1, almost_full_o 0
  - overflow_o 0, underflow_o 0
  - rd_valid_o 0, rd_data_o 0 (FWFT=0)
- Reset mid-operation discards all stored words. The first edge after rst_i deasserts behaves as from an empty FIFO.
- All status outputs are registered from next-count and change on the same edge as count_o. There are no combinational paths from inputs to any status output.
- Write latency:
  - A word written at edge N is readable after edge N: empty_o falls and, with FWFT=1, rd_data_o shows the word in cycle N+1.
  - The earliest accepted read of that word is at edge N+1.
- FWFT=0 read latency is 1. A read accepted at edge N gives data and rd_valid_o=1 during cycle N+1.
- Error flags rise on the edge that samples the offending request.

## Test plan
- FIFO_DEPTH=6, FWFT=1: write 0x10..0x15 on consecutive cycles.
  - Expect full_o=1 and count_o=6 after the 6th edge; almost_full_o=1 from count 4.
  - Then read 6 times: data 0x10..0x15 in order, empty_o=1 at the end, pointers wrapped 5→0 with no gaps.
- Full FIFO, write_i and read_i together: read accepted, write rejected, count_o 6→5, overflow_o=1.
  - Next cycle repeat write alone: accepted, count_o=6.
- Empty FIFO, read_i=1: underflow_o=1, count stays 0.
  - clr_err_i with read_i=1 in the same cycle: underflow_o stays 1.
  - clr_err_i alone: underflow_o=0.
- FWFT=0: write 0xAA, 0xBB, then read at edge N. Expect rd_data_o=0xAA and rd_valid_o=1 in cycle N+1 only; with no further read, rd_valid_o=0 while rd_data_o holds 0xAA.
- With 3 words stored, assert flush_i together with write_i: count_o=0, empty_o=1, almost_empty_o=1, no overflow. A following write of 0x55 reads back 0x55.
- Assert rst_i asynchronously mid-burst (between edges): all outputs take reset values immediately and hold until rst_i is released.
